// File: rtl/fu_store_queue_if.sv
// Store FU bundle: issue, flush, commit, completion report and data-memory write port.
interface fu_store_queue_if;
  logic        issued;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [4:0]  rob_index;
  logic [31:0] imm;
  logic [31:0] ps1_data;
  logic [31:0] ps2_data;
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic [4:0]  curr_rob_tag;
  logic        commit_valid;
  logic [4:0]  commit_tag;
  logic        sq_ready;
  logic        sq_done;
  logic [4:0]  sq_rob_tag;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;

  modport master (
    output issued, opcode, func3, rob_index, imm, ps1_data, ps2_data,
           mispredict, mispredict_tag, curr_rob_tag, commit_valid, commit_tag, mem_ack,
    input  sq_ready, sq_done, sq_rob_tag, mem_wr_en, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    input  issued, opcode, func3, rob_index, imm, ps1_data, ps2_data,
           mispredict, mispredict_tag, curr_rob_tag, commit_valid, commit_tag, mem_ack,
    output sq_ready, sq_done, sq_rob_tag, mem_wr_en, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/fu_store_queue.sv
// In-order store queue: executes stores into a FIFO, writes memory only after ROB commit,
// and drops speculative entries younger than a mispredicted branch.
module fu_store_queue #(
  parameter int DEPTH     = 8,
  parameter int ROB_DEPTH = 16
) (
  input logic             clk,
  input logic             reset,
  fu_store_queue_if.slave bus
);
  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [4:0]    TMASK    = 5'(ROB_DEPTH - 1);
  localparam logic [6:0]    OP_STORE = 7'b0100011;

  typedef enum logic {IDLE, WRITE} state_t;
  state_t state, state_nx;

  logic [DEPTH-1:0] vld, cmt;
  logic [4:0]       tag_q  [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [1:0]       size_q [DEPTH];
  logic [PW-1:0]    head, tail, tail_nx, cidx, idx;
  logic [CW-1:0]    count, count_nx, keep;
  logic [DEPTH-1:0] flush_mask, enq_mask, pop_mask, commit_mask;
  logic             enq, pop, load, cfound, flush_hit, commit_hit;
  logic             ready_q, done_q, wr_en_q;
  logic [4:0]       done_tag_q;
  logic [31:0]      maddr_q, mwdata_q, hd_wdata;
  logic [3:0]       mwstrb_q, hd_wstrb;
  logic [1:0]       b;

  // Tag t is strictly inside the circular window (m, c) modulo ROB_DEPTH.
  function automatic logic in_range(input logic [4:0] t, input logic [4:0] m,
                                    input logic [4:0] c);
    logic [4:0] d, w;
    d = (t - m) & TMASK;
    w = (c - m) & TMASK;
    return (d != 5'd0) && (d < w);
  endfunction

  assign enq = bus.issued && (bus.opcode == OP_STORE) &&
               (bus.func3 inside {3'b000, 3'b001, 3'b010}) &&
               (count < FULL) && !bus.mispredict;
  assign pop = (state == WRITE) && bus.mem_ack;

  // Walk live entries oldest-first: find the commit candidate and the oldest flushed slot.
  always_comb begin
    idx        = head;
    cidx       = head;
    cfound     = 1'b0;
    flush_hit  = 1'b0;
    keep       = count;
    flush_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && vld[idx] && !cmt[idx]) begin
        if (!cfound) begin
          cfound = 1'b1;
          cidx   = idx;
        end
        if (bus.mispredict && !flush_hit &&
            in_range(tag_q[idx], bus.mispredict_tag, bus.curr_rob_tag)) begin
          flush_hit = 1'b1;
          keep      = CW'(i);
        end
      end
      if (flush_hit && (CW'(i) < count)) flush_mask[idx] = 1'b1;
    end
  end

  always_comb begin
    commit_hit  = bus.commit_valid && cfound && (tag_q[cidx] == bus.commit_tag);
    commit_mask = commit_hit ? (DEPTH'(1) << cidx) : '0;
    enq_mask    = enq ? (DEPTH'(1) << tail) : '0;
    pop_mask    = pop ? (DEPTH'(1) << head) : '0;
    count_nx    = (flush_hit ? keep : count) + CW'(enq) - CW'(pop);
    tail_nx     = flush_hit ? (head + keep[PW-1:0]) : (tail + PW'(enq));
  end

  // Byte-lane steering of the head entry.
  always_comb begin
    b = addr_q[head][1:0];
    case (size_q[head])
      2'b00: begin
        hd_wdata = {4{data_q[head][7:0]}};
        hd_wstrb = 4'b0001 << b;
      end
      2'b01: begin
        hd_wdata = {2{data_q[head][15:0]}};
        hd_wstrb = 4'b0011 << {b[1], 1'b0};
      end
      default: begin
        hd_wdata = data_q[head];
        hd_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: if (vld[head] && cmt[head]) begin
        state_nx = WRITE;
        load     = 1'b1;
      end
      WRITE: if (bus.mem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      vld        <= '0;
      cmt        <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      done_tag_q <= '0;
      wr_en_q    <= 1'b0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
      mwstrb_q   <= '0;
    end else begin
      state   <= state_nx;
      vld     <= (vld & ~flush_mask & ~pop_mask) | enq_mask;
      cmt     <= (cmt | commit_mask) & ~pop_mask & ~enq_mask;
      head    <= head + PW'(pop);
      tail    <= tail_nx;
      count   <= count_nx;
      ready_q <= (count_nx < FULL);
      done_q  <= enq;
      if (enq) done_tag_q <= bus.rob_index;
      if (load) begin
        wr_en_q  <= 1'b1;
        maddr_q  <= {addr_q[head][31:2], 2'b00};
        mwdata_q <= hd_wdata;
        mwstrb_q <= hd_wstrb;
      end else if (pop) begin
        wr_en_q  <= 1'b0;
      end
    end
  end

  // Payload needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (enq) begin
      tag_q[tail]  <= bus.rob_index;
      addr_q[tail] <= bus.ps1_data + bus.imm;
      data_q[tail] <= bus.ps2_data;
      size_q[tail] <= bus.func3[1:0];
    end
  end

  assign bus.sq_ready   = ready_q;
  // A completion report for a store being flushed this cycle is withheld.
  assign bus.sq_done    = done_q &&
                          !(bus.mispredict && in_range(done_tag_q, bus.mispredict_tag, bus.curr_rob_tag));
  assign bus.sq_rob_tag = done_tag_q;
  assign bus.mem_wr_en  = wr_en_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_wdata  = mwdata_q;
  assign bus.mem_wstrb  = mwstrb_q;
endmodule

// File: tb/tb_fu_store_queue.sv
// Store queue bench: directed scenarios with literal expectations plus random traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_fu_store_queue;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fu_store_queue_if bus();
  fu_store_queue dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  sz;
    bit          c;
  } ent_t;

  ent_t        q[$];
  bit          m_wr = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [3:0]  m_strb = 0;
  bit          m_done = 0;
  logic [4:0]  m_dtag = 0;
  logic [4:0]  next_tag = 0;
  int          vecs = 0, errs = 0;

  function automatic bit in_rng(logic [4:0] t, logic [4:0] m, logic [4:0] c);
    int d, w;
    d = (int'(t) % 16 - int'(m) % 16 + 16) % 16;
    w = (int'(c) % 16 - int'(m) % 16 + 16) % 16;
    return d > 0 && d < w;
  endfunction

  function automatic void lanes(ent_t e, output logic [31:0] wd, output logic [3:0] st);
    for (int k = 0; k < 4; k++) begin
      case (e.sz)
        2'd0: begin st[k] = (k == int'(e.addr[1:0])); wd[8*k +: 8] = e.data[7:0]; end
        2'd1: begin st[k] = (k / 2 == int'(e.addr[1])); wd[8*k +: 8] = e.data[8*(k%2) +: 8]; end
        default: begin st[k] = 1'b1; wd[8*k +: 8] = e.data[8*k +: 8]; end
      endcase
    end
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one step per clock using the architectural rules.
  task automatic step();
    bit   pop, enq, idle_ready;
    int   keep, ci, pre_size;
    ent_t hd, e;
    pre_size   = q.size();
    pop        = m_wr && bus.mem_ack;
    idle_ready = !m_wr && pre_size > 0 && q[0].c;
    if (pre_size > 0) hd = q[0];
    keep = pre_size;
    if (bus.mispredict)
      for (int i = 0; i < pre_size; i++)
        if (!q[i].c && in_rng(q[i].tag, bus.mispredict_tag, bus.curr_rob_tag)) begin
          keep = i;
          break;
        end
    ci = -1;
    for (int i = 0; i < pre_size; i++) if (!q[i].c) begin ci = i; break; end
    if (bus.commit_valid && ci >= 0 && q[ci].tag == bus.commit_tag) q[ci].c = 1;
    while (q.size() > keep) void'(q.pop_back());
    enq = bus.issued && bus.opcode == OP_STORE && bus.func3 inside {3'd0, 3'd1, 3'd2} &&
          pre_size < 8 && !bus.mispredict;
    m_done = enq;
    if (enq) begin
      m_dtag = bus.rob_index;
      e.tag = bus.rob_index; e.addr = bus.ps1_data + bus.imm; e.data = bus.ps2_data;
      e.sz = bus.func3[1:0]; e.c = 0;
      q.push_back(e);
    end
    if (pop) begin
      void'(q.pop_front());
      m_wr = 0;
    end else if (idle_ready) begin
      m_wr   = 1;
      m_addr = {hd.addr[31:2], 2'b00};
      lanes(hd, m_wdata, m_strb);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      q.delete(); m_wr = 0; m_addr = 0; m_wdata = 0; m_strb = 0; m_done = 0; m_dtag = 0;
    end else step();
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      bit exp_done;
      exp_done = m_done && !(bus.mispredict && in_rng(m_dtag, bus.mispredict_tag, bus.curr_rob_tag));
      chk("sq_ready", bus.sq_ready, q.size() < 8);
      chk("sq_done", bus.sq_done, exp_done);
      if (exp_done) chk("sq_rob_tag", bus.sq_rob_tag, m_dtag);
      chk("mem_wr_en", bus.mem_wr_en, m_wr);
      if (m_wr) begin
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_wdata", bus.mem_wdata, m_wdata);
        chk("mem_wstrb", bus.mem_wstrb, m_strb);
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic clr();
    bus.issued = 0; bus.opcode = 0; bus.func3 = 0; bus.rob_index = 0; bus.imm = 0;
    bus.ps1_data = 0; bus.ps2_data = 0; bus.mispredict = 0; bus.mispredict_tag = 0;
    bus.curr_rob_tag = 0; bus.commit_valid = 0; bus.commit_tag = 0; bus.mem_ack = 0;
  endtask

  task automatic do_reset();
    reset = 1; clr(); next_tag = 0;
    tick(); tick();
    chk("rst sq_ready", bus.sq_ready, 1);
    chk("rst sq_done", bus.sq_done, 0);
    chk("rst sq_rob_tag", bus.sq_rob_tag, 0);
    chk("rst mem_wr_en", bus.mem_wr_en, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst mem_wdata", bus.mem_wdata, 0);
    chk("rst mem_wstrb", bus.mem_wstrb, 0);
    reset = 0;
  endtask

  task automatic st(logic [4:0] tag, logic [2:0] f3, logic [31:0] p1, logic [31:0] im,
                    logic [31:0] p2);
    bus.issued = 1; bus.opcode = OP_STORE; bus.func3 = f3; bus.rob_index = tag;
    bus.ps1_data = p1; bus.imm = im; bus.ps2_data = p2;
    tick();
    bus.issued = 0;
  endtask

  task automatic commit(logic [4:0] tag);
    bus.commit_valid = 1; bus.commit_tag = tag;
    tick();
    bus.commit_valid = 0;
  endtask

  task automatic wait_wr(string nm);
    int n = 0;
    while (bus.mem_wr_en !== 1'b1 && n < 20) begin tick(); n++; end
    chk(nm, bus.mem_wr_en, 1);
  endtask

  task automatic ack();
    bus.mem_ack = 1; tick(); bus.mem_ack = 0;
  endtask

  task automatic flush(logic [4:0] m, logic [4:0] c);
    bus.mispredict = 1; bus.mispredict_tag = m; bus.curr_rob_tag = c;
    tick();
    bus.mispredict = 0;
  endtask

  initial begin
    clr();
    // Basic SW path
    do_reset();
    st(5'd3, 3'b010, 32'h100, 32'd4, 32'hDEADBEEF);
    chk("t1 sq_done", bus.sq_done, 1);
    chk("t1 sq_rob_tag", bus.sq_rob_tag, 3);
    commit(5'd3);
    wait_wr("t1 wr_en");
    chk("t1 addr", bus.mem_addr, 32'h104);
    chk("t1 wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("t1 wstrb", bus.mem_wstrb, 4'b1111);
    tick(); tick();
    chk("t1 hold wr_en", bus.mem_wr_en, 1);
    chk("t1 hold addr", bus.mem_addr, 32'h104);
    ack();
    chk("t1 post-ack wr_en", bus.mem_wr_en, 0);
    chk("t1 post-ack ready", bus.sq_ready, 1);

    // Sub-word lanes
    st(5'd4, 3'b000, 32'h200, 32'd3, 32'h000000AB);
    commit(5'd4);
    wait_wr("t2 sb wr_en");
    chk("t2 sb addr", bus.mem_addr, 32'h200);
    chk("t2 sb wstrb", bus.mem_wstrb, 4'b1000);
    chk("t2 sb wdata", bus.mem_wdata, 32'hABABABAB);
    ack();
    st(5'd5, 3'b001, 32'h200, 32'd2, 32'h00001234);
    commit(5'd5);
    wait_wr("t2 sh wr_en");
    chk("t2 sh wstrb", bus.mem_wstrb, 4'b1100);
    chk("t2 sh wdata", bus.mem_wdata, 32'h12341234);
    ack();

    // Fill to full, ninth ignored
    do_reset();
    for (int i = 0; i < 8; i++) begin
      st(5'(i), 3'b010, 32'h300 + 32'(i * 4), 0, 32'(i));
      chk("t3 ready", bus.sq_ready, (i < 7) ? 1 : 0);
    end
    st(5'd8, 3'b010, 32'h400, 0, 32'h9);
    chk("t3 ninth no done", bus.sq_done, 0);
    chk("t3 still full", bus.sq_ready, 0);

    // Flush tags 4,6 of {2,4,6}
    do_reset();
    st(5'd2, 3'b010, 32'h1020, 0, 32'h2);
    st(5'd4, 3'b010, 32'h1040, 0, 32'h4);
    st(5'd6, 3'b010, 32'h1060, 0, 32'h6);
    bus.mispredict = 1; bus.mispredict_tag = 5'd3; bus.curr_rob_tag = 5'd7;
    #1 chk("t4 done suppressed", bus.sq_done, 0);
    tick();
    bus.mispredict = 0;
    for (int i = 0; i < 7; i++) begin
      st(5'(4 + i), 3'b010, 32'h2000 + 32'((4 + i) * 16), 0, 32'(i));
      chk("t4 ready after flush", bus.sq_ready, (i < 6) ? 1 : 0);
    end
    commit(5'd2);
    wait_wr("t4 wr1");
    chk("t4 first addr", bus.mem_addr, 32'h1020);
    ack();
    commit(5'd4);
    wait_wr("t4 wr2");
    chk("t4 slot1 addr", bus.mem_addr, 32'h2040);
    ack();

    // Wrap-around flush window
    do_reset();
    st(5'd14, 3'b010, 32'h500, 0, 0);
    st(5'd15, 3'b010, 32'h504, 0, 0);
    st(5'd0, 3'b010, 32'h508, 0, 0);
    flush(5'd15, 5'd1);
    for (int i = 0; i < 6; i++) begin
      st(5'(i), 3'b010, 32'h600 + 32'(i * 4), 0, 0);
      chk("t5 ready", bus.sq_ready, (i < 5) ? 1 : 0);
    end

    // Reset during a write
    do_reset();
    st(5'd1, 3'b010, 32'h700, 0, 32'h11);
    commit(5'd1);
    wait_wr("t6 wr_en");
    reset = 1;
    #1;
    chk("t6 reset wr_en", bus.mem_wr_en, 0);
    chk("t6 reset ready", bus.sq_ready, 1);
    chk("t6 reset done", bus.sq_done, 0);
    tick();
    reset = 0;
    next_tag = 0;

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      bit mis;
      int ci, k;
      logic [4:0] m;
      clr();
      bus.mem_ack = ($urandom_range(0, 2) == 0);
      mis = ($urandom_range(0, 24) == 0);
      bus.curr_rob_tag = next_tag;
      m = 0;
      if (mis) begin
        if (q.size() > 0) begin
          k = $urandom_range(0, q.size() - 1);
          m = q[k].tag;
        end else m = 5'((int'(next_tag) + 15) % 16);
        bus.mispredict = 1; bus.mispredict_tag = m;
      end else begin
        ci = -1;
        for (int i = 0; i < q.size(); i++) if (!q[i].c) begin ci = i; break; end
        if (ci >= 0 && $urandom_range(0, 2) == 0) begin
          bus.commit_valid = 1;
          bus.commit_tag = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 15)) : q[ci].tag;
        end
      end
      bus.issued = $urandom_range(0, 1);
      bus.opcode = ($urandom_range(0, 7) == 0) ? 7'h03 : OP_STORE;
      bus.func3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      bus.rob_index = next_tag;
      bus.ps1_data = $urandom; bus.imm = $urandom; bus.ps2_data = $urandom;
      if (bus.issued && bus.opcode == OP_STORE && bus.func3 <= 3'd2 && q.size() < 8 && !mis)
        next_tag = 5'((int'(next_tag) + 1) % 16);
      if (mis) next_tag = 5'((int'(m) + 1) % 16);
      tick();
    end
    clr();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
